// File: rtl/cic_rate_sequencer_if.sv
// rtl/cic_rate_sequencer_if.sv - control, gating and CIC-side signals of the rate sequencer
interface cic_rate_sequencer_if #(
    parameter int MSET_WIDTH = 9
) ();
    logic                  cfg_valid;
    logic [MSET_WIDTH-1:0] cfg_msetting;
    logic                  cfg_ready;
    logic                  cfg_err;
    logic                  up_s_axis_tvalid;
    logic                  up_s_axis_tready;
    logic                  cic_s_axis_tvalid;
    logic                  cic_s_axis_tready;
    logic                  cic_m_axis_tvalid;
    logic [MSET_WIDTH-1:0] msetting;
    logic                  cic_sync_reset;
    logic                  busy;
    logic                  drain_timeout;

    modport slave (
        input  cfg_valid, cfg_msetting, up_s_axis_tvalid, cic_s_axis_tready, cic_m_axis_tvalid,
        output cfg_ready, cfg_err, up_s_axis_tready, cic_s_axis_tvalid, msetting,
               cic_sync_reset, busy, drain_timeout
    );

    modport master (
        output cfg_valid, cfg_msetting, up_s_axis_tvalid, cic_s_axis_tready, cic_m_axis_tvalid,
        input  cfg_ready, cfg_err, up_s_axis_tready, cic_s_axis_tvalid, msetting,
               cic_sync_reset, busy, drain_timeout
    );
endinterface

// File: rtl/cic_rate_sequencer.sv
// rtl/cic_rate_sequencer.sv - drains, resets and re-settles a CIC decimator around an msetting change
module cic_rate_sequencer #(
    parameter int MSET_WIDTH    = 9,
    parameter int MIN_MSET      = 1,
    parameter int MAX_MSET      = 256,
    parameter int DEFAULT_MSET  = 256,
    parameter int DRAIN_CYCLES  = 32,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int RESET_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                async_reset_n,
    cic_rate_sequencer_if.slave bus
);
    localparam int MW1    = MSET_WIDTH + 1;
    localparam int IDLE_W = $clog2(DRAIN_CYCLES + 1);
    localparam int TOT_W  = $clog2(DRAIN_TIMEOUT + 1);
    localparam int PH_W   = $clog2(((RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES) + 1);

    typedef enum logic [1:0] {S_RESET, S_SETTLE, S_IDLE, S_DRAIN} state_t;

    state_t                r_state, w_state_nx;
    logic [IDLE_W-1:0]     r_idle_cnt, w_idle_cnt_nx;
    logic [TOT_W-1:0]      r_tot_cnt, w_tot_cnt_nx;
    logic [PH_W-1:0]       r_ph_cnt, w_ph_cnt_nx;
    logic [MSET_WIDTH-1:0] r_pending, w_pending_nx;
    logic [MSET_WIDTH-1:0] r_msetting, w_msetting_nx;
    logic                  r_cfg_err, w_cfg_err_nx;
    logic                  r_drain_timeout, w_drain_timeout_nx;
    logic                  r_cfg_ready;
    logic                  r_pass;
    logic                  r_busy;
    logic                  r_sync_reset;
    logic [MW1-1:0]        w_req;

    assign w_req = {1'b0, bus.cfg_msetting};

    always_comb begin
        w_state_nx         = r_state;
        w_idle_cnt_nx      = r_idle_cnt;
        w_tot_cnt_nx       = r_tot_cnt;
        w_ph_cnt_nx        = r_ph_cnt;
        w_pending_nx       = r_pending;
        w_msetting_nx      = r_msetting;
        w_cfg_err_nx       = 1'b0;
        w_drain_timeout_nx = r_drain_timeout;
        case (r_state)
            S_RESET: begin
                if (r_ph_cnt == PH_W'(RESET_CYCLES - 1)) begin
                    w_state_nx  = S_SETTLE;
                    w_ph_cnt_nx = '0;
                end else begin
                    w_ph_cnt_nx = (r_ph_cnt == '1) ? r_ph_cnt : r_ph_cnt + 1'b1;
                end
            end
            S_SETTLE: begin
                if (r_ph_cnt == PH_W'(SETTLE_CYCLES - 1)) begin
                    w_state_nx  = S_IDLE;
                    w_ph_cnt_nx = '0;
                end else begin
                    w_ph_cnt_nx = (r_ph_cnt == '1) ? r_ph_cnt : r_ph_cnt + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.cfg_valid && r_cfg_ready) begin
                    if (w_req < MW1'(MIN_MSET) || w_req > MW1'(MAX_MSET)) begin
                        w_cfg_err_nx = 1'b1;
                    end else if (bus.cfg_msetting == r_msetting) begin
                        w_drain_timeout_nx = 1'b0;
                    end else begin
                        w_pending_nx       = bus.cfg_msetting;
                        w_drain_timeout_nx = 1'b0;
                        w_state_nx         = S_DRAIN;
                        w_idle_cnt_nx      = '0;
                        w_tot_cnt_nx       = '0;
                    end
                end
            end
            S_DRAIN: begin
                // The idle-output exit wins when both exits coincide, so no timeout is flagged.
                if (!bus.cic_m_axis_tvalid && r_idle_cnt == IDLE_W'(DRAIN_CYCLES - 1)) begin
                    w_state_nx    = S_RESET;
                    w_ph_cnt_nx   = '0;
                    w_msetting_nx = r_pending;
                end else if (r_tot_cnt == TOT_W'(DRAIN_TIMEOUT - 1)) begin
                    w_state_nx         = S_RESET;
                    w_ph_cnt_nx        = '0;
                    w_msetting_nx      = r_pending;
                    w_drain_timeout_nx = 1'b1;
                end else begin
                    w_idle_cnt_nx = bus.cic_m_axis_tvalid ? '0 :
                                    ((r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + 1'b1);
                    w_tot_cnt_nx  = (r_tot_cnt == '1) ? r_tot_cnt : r_tot_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx  = S_RESET;
                w_ph_cnt_nx = '0;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            r_state         <= S_RESET;
            r_idle_cnt      <= '0;
            r_tot_cnt       <= '0;
            r_ph_cnt        <= '0;
            r_pending       <= MSET_WIDTH'(DEFAULT_MSET);
            r_msetting      <= MSET_WIDTH'(DEFAULT_MSET);
            r_cfg_err       <= 1'b0;
            r_drain_timeout <= 1'b0;
            r_cfg_ready     <= 1'b0;
            r_pass          <= 1'b0;
            r_busy          <= 1'b1;
            r_sync_reset    <= 1'b1;
        end else begin
            r_state         <= w_state_nx;
            r_idle_cnt      <= w_idle_cnt_nx;
            r_tot_cnt       <= w_tot_cnt_nx;
            r_ph_cnt        <= w_ph_cnt_nx;
            r_pending       <= w_pending_nx;
            r_msetting      <= w_msetting_nx;
            r_cfg_err       <= w_cfg_err_nx;
            r_drain_timeout <= w_drain_timeout_nx;
            r_cfg_ready     <= (w_state_nx == S_IDLE);
            r_pass          <= (w_state_nx == S_IDLE);
            r_busy          <= (w_state_nx != S_IDLE);
            r_sync_reset    <= (w_state_nx == S_RESET);
        end
    end

    assign bus.cic_s_axis_tvalid = bus.up_s_axis_tvalid & r_pass;
    assign bus.up_s_axis_tready  = bus.cic_s_axis_tready & r_pass;
    assign bus.cfg_ready         = r_cfg_ready;
    assign bus.cfg_err           = r_cfg_err;
    assign bus.msetting          = r_msetting;
    assign bus.cic_sync_reset    = r_sync_reset;
    assign bus.busy              = r_busy;
    assign bus.drain_timeout     = r_drain_timeout;
endmodule

// File: doc/cic_rate_sequencer.md
Name: cic_rate_sequencer

Overview:
- Controller that owns the decimation setting (msetting) of one CIC decimator instance and changes it safely at run time.
- On a rate-change request it:
  - blocks new input samples;
  - waits for the CIC pipeline and its output FIFO to drain;
  - loads the new msetting and pulses the CIC's sync_reset;
  - waits for the offset/correction ROMs to settle, then reopens the input.
- Sits between the upstream sample source / control plane and the CIC s_axis input.
- Only tvalid/tready are gated here; tdata is wired around this block.

Parameters:
- MSET_WIDTH, 9, width of msetting.
- MIN_MSET, 1, smallest legal msetting.
- MAX_MSET, 256, largest legal msetting.
- DEFAULT_MSET, 256, msetting loaded at reset.
- DRAIN_CYCLES, 32, consecutive idle-output cycles required before the pipeline counts as drained.
- DRAIN_TIMEOUT, 1024, maximum cycles spent in DRAIN before the reset is forced.
- RESET_CYCLES, 4, length of the cic_sync_reset pulse.
- SETTLE_CYCLES, 4, wait after reset for the ROM outputs to become valid.

Ports:
- clk  in  1  clock.
- async_reset_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- cfg_valid  in  1  rate-change request.
- cfg_msetting  in  MSET_WIDTH  requested msetting.
- cfg_ready  out  1  request accepted when cfg_valid & cfg_ready.
- cfg_err  out  1  one-cycle pulse: out-of-range request rejected.
- up_s_axis_tvalid  in  1  upstream sample valid.
- up_s_axis_tready  out  1  ready to upstream.
- cic_s_axis_tvalid  out  1  valid to the CIC input.
- cic_s_axis_tready  in  1  ready from the CIC input.
- cic_m_axis_tvalid  in  1  CIC output valid (monitor only).
- msetting  out  MSET_WIDTH  current setting driven to the CIC.
- cic_sync_reset  out  1  active-high synchronous reset to the CIC.
- busy  out  1  high when state != IDLE.
- drain_timeout  out  1  sticky; set on forced reset; cleared on the next accepted request.

Behaviour:
- Reset values (async_reset_n low):
  - state = RESET, counters = 0.
  - msetting = DEFAULT_MSET.
  - cic_sync_reset = 1, busy = 1.
  - cfg_ready = 0, cfg_err = 0, drain_timeout = 0, pass = 0.
- After reset release, the boot sequence runs: RESET → SETTLE → IDLE.
- Gating is combinational on the registered pass flag:
  - cic_s_axis_tvalid = up_s_axis_tvalid & pass.
  - up_s_axis_tready = cic_s_axis_tready & pass.
  - pass = 1 only in IDLE.
- cfg_ready = 1 only in IDLE. Requests arriving in any other state are held off, not dropped.
- IDLE, request accepted at cycle T:
  - cfg_msetting < MIN_MSET or > MAX_MSET: cfg_err = 1 at T+1; stay IDLE; msetting unchanged.
  - cfg_msetting == msetting: accepted as a no-op; stay IDLE; no gating; drain_timeout cleared.
  - Otherwise: latch the new value into pending; clear drain_timeout; go to DRAIN. pass = 0 from T+1.
- DRAIN:
  - idle_cnt increments each cycle cic_m_axis_tvalid = 0 and clears to 0 when it is 1.
  - tot_cnt increments every cycle.
  - idle_cnt == DRAIN_CYCLES-1 with cic_m_axis_tvalid = 0: go to RESET.
  - Else tot_cnt == DRAIN_TIMEOUT-1: go to RESET and set drain_timeout.
  - If both conditions hit in the same cycle, take the normal exit; drain_timeout stays 0.
- Entering RESET:
  - msetting <= pending on the same edge, so the ROMs address the new value while the CIC is held in reset.
  - cic_sync_reset = 1 for exactly RESET_CYCLES cycles, then go to SETTLE.
- SETTLE:
  - cic_sync_reset = 0; wait SETTLE_CYCLES cycles; go to IDLE.
  - pass = 1 and cfg_ready = 1 from the first IDLE cycle.
- Nominal request-to-ready latency with an already-empty output: 1 + DRAIN_CYCLES + RESET_CYCLES + SETTLE_CYCLES = 41 cycles at defaults.
- Counters saturate and never wrap; each counter is cleared on state entry.
- Asynchronous reset mid-sequence:
  - Abort the sequence immediately; msetting reverts to DEFAULT_MSET; the pending value is discarded; the boot sequence reruns.
- Output FIFO that never empties (downstream m_axis_tready stuck low): the timeout path guarantees progress; the CIC reset flushes the FIFO.
- No combinational path from cfg_* to any output other than via registers. cfg_ready and busy are registered.

Test Plan:
- Boot: release async_reset_n → cic_sync_reset high 4 cycles, then low; cfg_ready rises 4 cycles later; msetting = 256; up_s_axis_tready follows cic_s_axis_tready.
- Normal change 256 → 64 with the output empty: cfg_ready drops next cycle; up_s_axis_tready = 0 for the whole sequence; msetting = 64 on the first reset cycle; sync_reset pulse = 4 cycles; cfg_ready = 1 exactly 41 cycles after acceptance.
- Invalid request cfg_msetting = 0 and then 300: cfg_err pulses once each; msetting unchanged; busy stays 0; data flow is never gated.
- Same-value request 64 while msetting = 64: accepted; busy stays 0; no sync_reset pulse.
- cic_m_axis_tvalid held high throughout DRAIN: reset forced after 1024 DRAIN cycles; drain_timeout = 1; the next valid request clears it.
- async_reset_n asserted mid-DRAIN of a 256 → 32 change: outputs return to reset values immediately; after release msetting = 256, the boot sequence repeats, and 32 is never applied.
